// File: rtl/card_deck_shuffler_if.sv
// Card-deal request/write bundle between the game controller and the deck shuffler.
// The shuffler takes the slave side; the requester (or bench) takes the master side.
interface card_deck_shuffler_if;
    logic       Start;
    logic [7:0] Seed;
    logic       WriteEnable;
    logic [5:0] DataOut;
    logic [3:0] DataLoc;
    logic       Busy;
    logic       Done;

    modport master (
        output Start, Seed,
        input  WriteEnable, DataOut, DataLoc, Busy, Done
    );

    modport slave (
        input  Start, Seed,
        output WriteEnable, DataOut, DataLoc, Busy, Done
    );
endinterface

// File: rtl/card_deck_shuffler.sv
// Seeded 16-card deck builder: LFSR-driven Fisher-Yates shuffle, then streams the deck to card memory.
// Define DECK_FIXED_LAYOUT_EN to skip the shuffle and write the unshuffled debug layout.
module card_deck_shuffler #(
    parameter logic [1:0] FACE_DOWN_FLAGS = 2'b01,
    parameter logic [7:0] ZERO_SEED_SUB   = 8'hA5
) (
    input logic                 Clk,
    input logic                 Reset,
    card_deck_shuffler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHUFFLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] i_q, i_d;
    logic [3:0] k_q, k_d;
    logic [3:0] deck_q [16];
    logic [3:0] deck_d [16];
    logic       we_q, we_d;
    logic [5:0] data_q, data_d;
    logic [3:0] loc_q, loc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] r;
    logic [7:0] lfsr_step;

    assign r         = lfsr_q[3:0];
    assign lfsr_step = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        i_d     = i_q;
        k_d     = k_q;
        deck_d  = deck_q;
        loc_d   = loc_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    lfsr_d  = (bus.Seed == 8'h00) ? ZERO_SEED_SUB : bus.Seed;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                for (int n = 0; n < 16; n++) begin
                    deck_d[n] = 4'((n >> 1) + 1);
                end
                i_d = 4'd15;
                k_d = 4'd0;
`ifdef DECK_FIXED_LAYOUT_EN
                state_d = S_WRITE;
`else
                state_d = S_SHUFFLE;
`endif
            end
`ifndef DECK_FIXED_LAYOUT_EN
            S_SHUFFLE: begin
                lfsr_d = lfsr_step;
                // Draws above i are rejected so every position stays uniformly chosen.
                if (r <= i_q) begin
                    deck_d[i_q] = deck_q[r];
                    deck_d[r]   = deck_q[i_q];
                    i_d         = i_q - 4'd1;
                    if (i_q == 4'd1) begin
                        k_d     = 4'd0;
                        state_d = S_WRITE;
                    end
                end
            end
`endif
            S_WRITE: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the first write lands in the WRITE entry cycle.
        we_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (we_d) begin
            loc_d  = k_d;
            data_d = {FACE_DOWN_FLAGS, deck_d[k_d]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= 8'h00;
            i_q     <= 4'd0;
            k_q     <= 4'd0;
            we_q    <= 1'b0;
            data_q  <= 6'd0;
            loc_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            i_q     <= i_d;
            k_q     <= k_d;
            we_q    <= we_d;
            data_q  <= data_d;
            loc_q   <= loc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Deck contents are don't-care until LOAD, so they carry no reset.
    always_ff @(posedge Clk) begin
        deck_q <= deck_d;
    end

    assign bus.WriteEnable = we_q;
    assign bus.DataOut     = data_q;
    assign bus.DataLoc     = loc_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;

endmodule
